// File: rtl/alu_issue_pkg.sv
// Shared definitions for the RV32I issue stage: ALU opcode encoding,
// base opcode values and the ID/EX entry layout.
package alu_issue_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLL   = 4'd6,
    ALU_SLTU  = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_COPY1 = 4'd10,
    ALU_COPY2 = 4'd11
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    alu_op_e          alu_op;
    logic [XLEN-1:0]  in1;
    logic [XLEN-1:0]  in2;
    logic [4:0]       rd;
    logic             we;
    logic [XLEN-1:0]  pc;
    logic             illegal;
  } issue_entry_t;

  // funct3 selects the arithmetic operation; alt (funct7[5]) picks SUB/SRA
  function automatic alu_op_e arith_op(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    op = ALU_ADD;
    case (funct3)
      3'd0: op = alt ? ALU_SUB : ALU_ADD;
      3'd1: op = ALU_SLL;
      3'd2: op = ALU_SLT;
      3'd3: op = ALU_SLTU;
      3'd4: op = ALU_XOR;
      3'd5: op = alt ? ALU_SRA : ALU_SRL;
      3'd6: op = ALU_OR;
      3'd7: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decoder: instruction word, PC and register reads in,
// ALU opcode, operands, destination and write enable out. Only muxing and
// sign extension happen here; the ALU forms PC+imm and PC+4.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output alu_op_e     alu_op,
  output logic [31:0] in1,
  output logic [31:0] in2,
  output logic [4:0]  rd,
  output logic        we,
  output logic        illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [31:0] shamt;
  logic        writes_rd;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign shamt  = {27'b0, instr[24:20]};

  // Opcode/funct decode; undecodable encodings keep the ADD/zero defaults
  always_comb begin
    alu_op    = ALU_ADD;
    in1       = '0;
    in2       = '0;
    writes_rd = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5))) begin
          alu_op    = arith_op(funct3, funct7[5]);
          in1       = rs1_data;
          in2       = rs2_data;
          writes_rd = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        if (funct3 == 3'd1) begin
          if (funct7 == 7'h00) begin
            alu_op    = ALU_SLL;
            in1       = rs1_data;
            in2       = shamt;
            writes_rd = 1'b1;
          end else begin
            illegal = 1'b1;
          end
        end else if (funct3 == 3'd5) begin
          if (funct7 == 7'h00 || funct7 == 7'h20) begin
            alu_op    = arith_op(funct3, funct7[5]);
            in1       = rs1_data;
            in2       = shamt;
            writes_rd = 1'b1;
          end else begin
            illegal = 1'b1;
          end
        end else begin
          alu_op    = arith_op(funct3, 1'b0);
          in1       = rs1_data;
          in2       = imm_i;
          writes_rd = 1'b1;
        end
      end
      OPC_LUI: begin
        alu_op    = ALU_COPY2;
        in2       = imm_u;
        writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        in1       = pc;
        in2       = imm_u;
        writes_rd = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        in1       = pc;
        in2       = 32'd4;
        writes_rd = 1'b1;
      end
      OPC_LOAD: begin
        in1       = rs1_data;
        in2       = imm_i;
        writes_rd = 1'b1;
      end
      OPC_STORE: begin
        in1 = rs1_data;
        in2 = imm_s;
      end
      OPC_BRANCH: begin
        in1 = rs1_data;
        in2 = rs2_data;
        case (funct3)
          3'd0, 3'd1: alu_op = ALU_SUB;
          3'd4, 3'd5: alu_op = ALU_SLT;
          3'd6, 3'd7: alu_op = ALU_SLTU;
          default: begin
            alu_op  = ALU_ADD;
            in1     = '0;
            in2     = '0;
            illegal = 1'b1;
          end
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  assign we = writes_rd & (rd != 5'd0) & ~illegal;

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register with valid/ready handshake feeding the ALU.
// Optional macro ISSUE_SKID_EN adds a second (skid) entry so id_ready
// becomes a flop with no combinational path from ex_ready.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_instr,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [3:0]      ex_alu_op,
  output logic [XLEN-1:0] ex_in1,
  output logic [XLEN-1:0] ex_in2,
  output logic [4:0]      ex_rd,
  output logic            ex_we,
  output logic [XLEN-1:0] ex_pc,
  output logic            ex_illegal
);

  localparam issue_entry_t RESET_ENTRY = '{
    alu_op: ALU_ADD, in1: '0, in2: '0, rd: '0, we: 1'b0, pc: RESET_PC, illegal: 1'b0
  };

  issue_entry_t dec_entry;
  issue_entry_t ex_q, ex_d;
  logic         ex_valid_q, ex_valid_d;
  logic         accept;
  logic         pop;

  alu_issue_decode u_decode (
    .instr    (id_instr),
    .pc       (id_pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .alu_op   (dec_entry.alu_op),
    .in1      (dec_entry.in1),
    .in2      (dec_entry.in2),
    .rd       (dec_entry.rd),
    .we       (dec_entry.we),
    .illegal  (dec_entry.illegal)
  );

  assign dec_entry.pc = id_pc;
  assign pop          = ex_valid_q & ex_ready;
  assign accept       = id_valid & id_ready;

`ifdef ISSUE_SKID_EN
  issue_entry_t skid_q, skid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         id_ready_q, id_ready_d;

  assign id_ready = id_ready_q;

  // Main/skid next state: skid refills main first so order is preserved
  always_comb begin
    ex_d         = ex_q;
    ex_valid_d   = ex_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      ex_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (pop) begin
        ex_d         = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!ex_valid_q || pop) begin
        ex_d       = dec_entry;
        ex_valid_d = 1'b1;
      end else begin
        skid_d       = dec_entry;
        skid_valid_d = 1'b1;
      end
    end else if (pop) begin
      ex_valid_d = 1'b0;
    end
    id_ready_d = ~skid_valid_d;
  end

  // Skid entry and registered ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q       <= RESET_ENTRY;
      skid_valid_q <= 1'b0;
      id_ready_q   <= 1'b1;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      id_ready_q   <= id_ready_d;
    end
  end
`else
  assign id_ready = ~ex_valid_q | ex_ready;

  // Single-entry next state: flush beats accept, accept beats drain
  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_d       = dec_entry;
      ex_valid_d = 1'b1;
    end else if (pop) begin
      ex_valid_d = 1'b0;
    end
  end
`endif

  // ID/EX register presented to the ALU
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q       <= RESET_ENTRY;
      ex_valid_q <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_alu_op  = ex_q.alu_op;
  assign ex_in1     = ex_q.in1;
  assign ex_in2     = ex_q.in2;
  assign ex_rd      = ex_q.rd;
  assign ex_we      = ex_q.we;
  assign ex_pc      = ex_q.pc;
  assign ex_illegal = ex_q.illegal;

endmodule
